// File: rtl/rs_pkg.sv
// Shared types for the unified reservation station: FU ids and the per-entry record.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rs_pkg;

  localparam int RS_TAG_W = 6;
  localparam int RS_FU_W  = 2;

  localparam logic [RS_FU_W-1:0] FU_ALU = 2'd0;
  localparam logic [RS_FU_W-1:0] FU_LSU = 2'd1;
  localparam logic [RS_FU_W-1:0] FU_MUL = 2'd2;

  typedef struct packed {
    logic                valid;
    logic [RS_FU_W-1:0]  fu;
    logic [31:0]         pc;
    logic [31:0]         inst;
    logic [RS_TAG_W-1:0] prs1;
    logic [RS_TAG_W-1:0] prs2;
    logic [RS_TAG_W-1:0] prd;
    logic                rdy1;
    logic                rdy2;
  } rs_entry_t;

endpackage

// File: rtl/rs_slot.sv
// One reservation-station entry: storage, multi-bus CDB wakeup and allocate-time bypass.
// Latency: allocation and wakeup visible one edge later; no same-cycle issue after wakeup.
// Backpressure: none locally; the top only clears the entry when its issue handshake fires.
module rs_slot
  import rs_pkg::*;
#(
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = RS_TAG_W
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     alloc_en,
  input  logic                     issue_clr,
  input  rs_entry_t                alloc_dat,
  input  logic [NUM_CDB-1:0]       cdb_en_i,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag_i,
  output rs_entry_t                ent
);

  logic hit1, hit2, byp1, byp2;

  // Compare every enabled bus against the stored sources and the incoming sources.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    byp1 = 1'b0;
    byp2 = 1'b0;
    for (int b = 0; b < NUM_CDB; b++) begin
      if (cdb_en_i[b]) begin
        if (cdb_tag_i[b*TAG_W +: TAG_W] == ent.prs1)       hit1 = 1'b1;
        if (cdb_tag_i[b*TAG_W +: TAG_W] == ent.prs2)       hit2 = 1'b1;
        if (cdb_tag_i[b*TAG_W +: TAG_W] == alloc_dat.prs1) byp1 = 1'b1;
        if (cdb_tag_i[b*TAG_W +: TAG_W] == alloc_dat.prs2) byp2 = 1'b1;
      end
    end
  end

  // Entry state: reset > flush > allocate > issue-free > wakeup (wakeup only while valid).
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ent <= '0;
    end else if (flush_i) begin
      ent <= '0;
    end else if (alloc_en) begin
      ent      <= alloc_dat;
      ent.rdy1 <= alloc_dat.rdy1 | byp1;
      ent.rdy2 <= alloc_dat.rdy2 | byp2;
    end else if (issue_clr) begin
      ent.valid <= 1'b0;
    end else if (ent.valid) begin
      if (hit1) ent.rdy1 <= 1'b1;
      if (hit2) ent.rdy2 <= 1'b1;
    end
  end

endmodule

// File: rtl/rs_unified.sv
// Unified reservation station: DEPTH entries, oldest-ready issue per FU channel via an age matrix.
// Latency: alloc-to-issue 1 cycle minimum; issue select is combinational from registered state.
// Backpressure: alloc_ready_o drops when no entry is free; an unaccepted issue stays presented.
module rs_unified
  import rs_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_FU  = 3,
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = 6,
  parameter int FU_W    = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      alloc_valid_i,
  output logic                      alloc_ready_o,
  input  logic [FU_W-1:0]           alloc_fu_i,
  input  logic [31:0]               alloc_pc_i,
  input  logic [31:0]               alloc_inst_i,
  input  logic [TAG_W-1:0]          alloc_prs1_i,
  input  logic [TAG_W-1:0]          alloc_prs2_i,
  input  logic [TAG_W-1:0]          alloc_prd_i,
  input  logic                      alloc_prs1_rdy_i,
  input  logic                      alloc_prs2_rdy_i,
  input  logic [NUM_CDB-1:0]        cdb_en_i,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag_i,
  output logic [NUM_FU-1:0]         issue_valid_o,
  input  logic [NUM_FU-1:0]         issue_ready_i,
  output logic [NUM_FU*32-1:0]      issue_pc_o,
  output logic [NUM_FU*32-1:0]      issue_inst_o,
  output logic [NUM_FU*TAG_W-1:0]   issue_prs1_o,
  output logic [NUM_FU*TAG_W-1:0]   issue_prs2_o,
  output logic [NUM_FU*TAG_W-1:0]   issue_prd_o,
  output logic [$clog2(DEPTH):0]    free_count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  rs_entry_t        ent [DEPTH];
  rs_entry_t        alloc_dat;
  logic [DEPTH-1:0] vld, rdy, alloc_oh, clr;
  logic [DEPTH-1:0] older [DEPTH];   // older[j][i]=1: entry j was allocated before entry i
  logic [DEPTH-1:0] cand [NUM_FU];
  logic [DEPTH-1:0] pick [NUM_FU];
  logic [CW-1:0]    free_cnt;
  logic             found, alloc_fire;

  // Pack the dispatch fields into the entry record written on allocation.
  always_comb begin
    alloc_dat       = '0;
    alloc_dat.valid = 1'b1;
    alloc_dat.fu    = alloc_fu_i;
    alloc_dat.pc    = alloc_pc_i;
    alloc_dat.inst  = alloc_inst_i;
    alloc_dat.prs1  = alloc_prs1_i;
    alloc_dat.prs2  = alloc_prs2_i;
    alloc_dat.prd   = alloc_prd_i;
    alloc_dat.rdy1  = alloc_prs1_rdy_i;
    alloc_dat.rdy2  = alloc_prs2_rdy_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    rs_slot #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W)) u_slot (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .flush_i   (flush_i),
      .alloc_en  (alloc_oh[i] & alloc_fire),
      .issue_clr (clr[i]),
      .alloc_dat (alloc_dat),
      .cdb_en_i  (cdb_en_i),
      .cdb_tag_i (cdb_tag_i),
      .ent       (ent[i])
    );
    assign vld[i] = ent[i].valid;
    assign rdy[i] = ent[i].valid & ent[i].rdy1 & ent[i].rdy2;
  end

  // Count free entries and pick the lowest-index free one; registered state only.
  always_comb begin
    free_cnt = '0;
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!vld[i]) begin
        free_cnt = free_cnt + CW'(1);
        if (!found) begin
          alloc_oh[i] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

  assign free_count_o  = free_cnt;
  assign alloc_ready_o = (free_cnt != '0);
  assign alloc_fire    = alloc_valid_i & alloc_ready_o & ~flush_i;

  // Age matrix: the new entry becomes younger than every currently valid entry.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int k = 0; k < DEPTH; k++) older[k] <= '0;
    end else if (alloc_fire) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc_oh[k]) begin
          for (int j = 0; j < DEPTH; j++) begin
            older[k][j] <= 1'b0;
            if (vld[j]) older[j][k] <= 1'b1;
          end
        end
      end
    end
  end

  // Per channel, keep the ready entries that no older ready same-FU entry beats.
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      cand[f] = '0;
      pick[f] = '0;
    end
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < DEPTH; i++)
        cand[f][i] = rdy[i] && (ent[i].fu == RS_FU_W'(f));
      for (int i = 0; i < DEPTH; i++) begin
        pick[f][i] = cand[f][i];
        for (int j = 0; j < DEPTH; j++)
          if (j != i && cand[f][j] && older[j][i]) pick[f][i] = 1'b0;
      end
    end
  end

  // One-hot payload mux per channel; zero when nothing is selected. Fired picks free their slot.
  always_comb begin
    issue_valid_o = '0;
    issue_pc_o    = '0;
    issue_inst_o  = '0;
    issue_prs1_o  = '0;
    issue_prs2_o  = '0;
    issue_prd_o   = '0;
    clr           = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      issue_valid_o[f] = |pick[f];
      for (int i = 0; i < DEPTH; i++) begin
        if (pick[f][i]) begin
          issue_pc_o[f*32 +: 32]      = ent[i].pc;
          issue_inst_o[f*32 +: 32]    = ent[i].inst;
          issue_prs1_o[f*TAG_W +: TAG_W] = ent[i].prs1;
          issue_prs2_o[f*TAG_W +: TAG_W] = ent[i].prs2;
          issue_prd_o[f*TAG_W +: TAG_W]  = ent[i].prd;
          if (issue_ready_i[f]) clr[i] = 1'b1;
        end
      end
    end
  end

  // Interface sanity: legal FU id on allocation, no duplicate tag across enabled buses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      if (alloc_valid_i && alloc_ready_o && !flush_i)
        assert (int'(alloc_fu_i) < NUM_FU) else $error("rs_unified: alloc_fu_i out of range");
      for (int a = 0; a < NUM_CDB; a++)
        for (int b = a + 1; b < NUM_CDB; b++)
          if (cdb_en_i[a] && cdb_en_i[b])
            assert (cdb_tag_i[a*TAG_W +: TAG_W] != cdb_tag_i[b*TAG_W +: TAG_W])
              else $error("rs_unified: duplicate CDB tag");
    end
  end

endmodule

// File: tb/tb_rs_unified.sv
// Bench for rs_unified: directed scenarios plus random traffic against an age-ordered queue model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: issue_ready and alloc_valid driven both directed and randomly.
module tb_rs_unified;
  import rs_pkg::*;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n, flush, alloc_valid, alloc_ready, r1_in, r2_in;
  logic [1:0]   alloc_fu;
  logic [31:0]  alloc_pc, alloc_inst;
  logic [5:0]   s1_in, s2_in, d_in;
  logic [1:0]   cdb_en;
  logic [11:0]  cdb_tag;
  logic [2:0]   issue_valid, issue_ready;
  logic [95:0]  issue_pc, issue_inst;
  logic [17:0]  issue_prs1, issue_prs2, issue_prd;
  logic [3:0]   free_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         fu;
    logic [31:0] pc, inst;
    logic [5:0] s1, s2, d;
    bit         r1, r2;
  } m_t;
  m_t q[$];   // valid entries, oldest first

  always #5 clk = ~clk;

  rs_unified dut (
    .clk_i(clk), .reset_i(rst_n), .flush_i(flush),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_fu_i(alloc_fu),
    .alloc_pc_i(alloc_pc), .alloc_inst_i(alloc_inst),
    .alloc_prs1_i(s1_in), .alloc_prs2_i(s2_in), .alloc_prd_i(d_in),
    .alloc_prs1_rdy_i(r1_in), .alloc_prs2_rdy_i(r2_in),
    .cdb_en_i(cdb_en), .cdb_tag_i(cdb_tag),
    .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
    .issue_pc_o(issue_pc), .issue_inst_o(issue_inst),
    .issue_prs1_o(issue_prs1), .issue_prs2_o(issue_prs2), .issue_prd_o(issue_prd),
    .free_count_o(free_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit on_cdb(input logic [5:0] t);
    for (int b = 0; b < 2; b++)
      if (cdb_en[b] && cdb_tag[b*6 +: 6] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_alloc(input bit v, input logic [1:0] fu, input logic [5:0] s1, input logic [5:0] s2,
                           input logic [5:0] d, input bit r1, input bit r2);
    alloc_valid = v;
    alloc_fu    = fu;
    s1_in = s1; s2_in = s2; d_in = d;
    r1_in = r1; r2_in = r2;
    alloc_pc    = $urandom;
    alloc_inst  = $urandom;
  endtask

  // Compare DUT against the model, advance the model by one edge, then step the clock.
  task automatic step();
    int          sel [3];
    logic [2:0]  ev;
    logic [95:0] epc, einst;
    logic [17:0] e1, e2, ed;
    m_t          nq[$];
    m_t          n;
    bit          take;
    ev = '0; epc = '0; einst = '0; e1 = '0; e2 = '0; ed = '0;
    for (int f = 0; f < 3; f++) begin
      sel[f] = -1;
      for (int i = 0; i < q.size(); i++)
        if (sel[f] < 0 && q[i].fu == f && q[i].r1 && q[i].r2) sel[f] = i;
      if (sel[f] >= 0) begin
        ev[f] = 1'b1;
        epc[f*32 +: 32]   = q[sel[f]].pc;
        einst[f*32 +: 32] = q[sel[f]].inst;
        e1[f*6 +: 6] = q[sel[f]].s1;
        e2[f*6 +: 6] = q[sel[f]].s2;
        ed[f*6 +: 6] = q[sel[f]].d;
      end
    end
    chk("issue_valid", 128'(issue_valid), 128'(ev));
    chk("issue_pc",    128'(issue_pc),    128'(epc));
    chk("issue_inst",  128'(issue_inst),  128'(einst));
    chk("issue_prs1",  128'(issue_prs1),  128'(e1));
    chk("issue_prs2",  128'(issue_prs2),  128'(e2));
    chk("issue_prd",   128'(issue_prd),   128'(ed));
    chk("free_count",  128'(free_count),  128'(DEPTH - q.size()));
    chk("alloc_ready", 128'(alloc_ready), 128'(q.size() < DEPTH));
    if (flush) begin
      q.delete();
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        take = 1'b0;
        for (int f = 0; f < 3; f++)
          if (sel[f] == i && issue_ready[f]) take = 1'b1;
        if (!take) begin
          n = q[i];
          if (on_cdb(n.s1)) n.r1 = 1'b1;
          if (on_cdb(n.s2)) n.r2 = 1'b1;
          nq.push_back(n);
        end
      end
      if (alloc_valid && q.size() < DEPTH) begin
        n.fu = int'(alloc_fu); n.pc = alloc_pc; n.inst = alloc_inst;
        n.s1 = s1_in; n.s2 = s2_in; n.d = d_in;
        n.r1 = r1_in | on_cdb(s1_in);
        n.r2 = r2_in | on_cdb(s2_in);
        nq.push_back(n);
      end
      q = nq;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; cdb_en = '0; cdb_tag = '0; issue_ready = '0;
    set_alloc(1'b0, FU_ALU, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);

    // 1. Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_free_count",  128'(free_count),  128'(8));
    chk("rst_alloc_ready", 128'(alloc_ready), 128'(1));
    chk("rst_issue_valid", 128'(issue_valid), 128'(0));
    chk("rst_issue_prd",   128'(issue_prd),   128'(0));
    chk("rst_issue_pc",    128'(issue_pc),    128'(0));
    rst_n = 1'b1;

    // 2. Age ordering on the ALU channel
    for (int k = 0; k < 3; k++) begin
      set_alloc(1'b1, FU_ALU, 6'd1, 6'd2, 6'(10 + k), 1'b1, 1'b1);
      step();
    end
    set_alloc(1'b0, FU_ALU, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    issue_ready = 3'b001;
    for (int k = 0; k < 3; k++) begin
      chk("age_valid", 128'(issue_valid[0]), 128'(1));
      chk("age_prd",   128'(issue_prd[5:0]), 128'(10 + k));
      step();
    end
    chk("age_drained", 128'(issue_valid), 128'(0));

    // 3. Wakeup from bus 0: issuable the cycle after the broadcast
    issue_ready = 3'b000;
    set_alloc(1'b1, FU_MUL, 6'd5, 6'd9, 6'd20, 1'b0, 1'b1);
    step();
    set_alloc(1'b0, FU_ALU, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    issue_ready = 3'b100;
    chk("wake_before", 128'(issue_valid[2]), 128'(0));
    cdb_en = 2'b01; cdb_tag = {6'd0, 6'd5};
    chk("wake_same_cycle", 128'(issue_valid[2]), 128'(0));
    step();
    cdb_en = 2'b00;
    chk("wake_after", 128'(issue_valid[2]), 128'(1));
    chk("wake_prd",   128'(issue_prd[17:12]), 128'(20));
    step();
    chk("wake_gone", 128'(issue_valid), 128'(0));

    // 4. Allocate bypass from bus 1
    issue_ready = 3'b010;
    set_alloc(1'b1, FU_LSU, 6'd3, 6'd7, 6'd21, 1'b1, 1'b0);
    cdb_en = 2'b10; cdb_tag = {6'd7, 6'd0};
    step();
    cdb_en = 2'b00;
    set_alloc(1'b0, FU_ALU, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    chk("byp_valid", 128'(issue_valid[1]), 128'(1));
    chk("byp_prd",   128'(issue_prd[11:6]), 128'(21));
    step();
    chk("byp_gone", 128'(issue_valid), 128'(0));

    // 5. Full and backpressure
    issue_ready = 3'b000;
    for (int k = 0; k < 8; k++) begin
      set_alloc(1'b1, FU_ALU, 6'd1, 6'd2, 6'(30 + k), 1'b1, 1'b1);
      step();
    end
    chk("full_ready", 128'(alloc_ready), 128'(0));
    chk("full_count", 128'(free_count),  128'(0));
    issue_ready = 3'b001;
    set_alloc(1'b1, FU_ALU, 6'd1, 6'd2, 6'd40, 1'b1, 1'b1);
    step();
    issue_ready = 3'b000;
    chk("full_after_issue", 128'(free_count), 128'(1));
    chk("full_ready_again", 128'(alloc_ready), 128'(1));
    step();
    chk("full_refill", 128'(free_count), 128'(0));
    set_alloc(1'b0, FU_ALU, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    issue_ready = 3'b001;
    repeat (8) step();
    chk("full_drained", 128'(free_count), 128'(8));

    // 6. Flush with an allocation in the same cycle
    issue_ready = 3'b000;
    for (int k = 0; k < 5; k++) begin
      set_alloc(1'b1, 2'(k % 3), 6'(40 + k), 6'd2, 6'(50 + k), k[0], 1'b1);
      step();
    end
    flush = 1'b1;
    set_alloc(1'b1, FU_ALU, 6'd1, 6'd2, 6'd59, 1'b1, 1'b1);
    step();
    flush = 1'b0;
    set_alloc(1'b0, FU_ALU, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    chk("flush_count", 128'(free_count),  128'(8));
    chk("flush_valid", 128'(issue_valid), 128'(0));
    issue_ready = 3'b111;
    repeat (3) step();
    chk("flush_dropped", 128'(issue_valid), 128'(0));

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      set_alloc($urandom_range(0, 9) < 7, 2'($urandom_range(0, 2)),
                6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      cdb_en  = 2'($urandom_range(0, 3));
      cdb_tag = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
      if (cdb_tag[11:6] == cdb_tag[5:0]) cdb_tag[11:6] = cdb_tag[5:0] ^ 6'd1;
      issue_ready = 3'($urandom_range(0, 7));
      flush = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
